// File: rtl/clk_100ms_divider.sv
`timescale 1ns/1ps
// Purpose: divides clk by 2*HALF_PERIOD into a 50% duty clk_out plus a one-cycle tick on each clk_out rise.
// Latency: outputs are registered; reset reaches the outputs one clk edge after rst is sampled high.
// Backpressure: none; free-running time base with no handshake, consumers sample tick every cycle.
module clk_100ms_divider #(
    parameter int HALF_PERIOD = 5_000_000,
    parameter int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    // Terminal count of one half-period; $clog2(N) bits always hold N-1.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    // Declaration initialisers give the FPGA/simulation power-up state, so the
    // block runs X-free even with rst tied low.
    logic [CNT_W-1:0] cnt      = '0;
    logic             clk_out_q = 1'b0;
    logic             tick_q    = 1'b0;
    logic             wrap;

    // End of the current half-period: the edge that toggles clk_out.
    assign wrap = (cnt == LAST);

    // Half-period counter; wraps at LAST so it never reaches 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Divided clock flop; reset has priority over a toggle due on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_q <= 1'b0;
        end else if (wrap) begin
            clk_out_q <= ~clk_out_q;
        end
    end

    // Tick fires only for the low-to-high toggle, aligned with clk_out's first high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap & ~clk_out_q;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_100ms_divider.sv
`timescale 1ns/1ps
// Bench for clk_100ms_divider: HALF_PERIOD=4 and HALF_PERIOD=1 instances on a 2 ns clock.
module tb_clk_100ms_divider;

    logic clk  = 1'b0;
    logic rst4 = 1'b0;
    logic rst1 = 1'b0;
    logic clk_out4, tick4, clk_out1, tick1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic exp_clk;
        logic exp_tick;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    clk_100ms_divider #(.HALF_PERIOD(4)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .clk_out (clk_out4),
        .tick    (tick4)
    );

    clk_100ms_divider #(.HALF_PERIOD(1)) dut1 (
        .clk     (clk),
        .rst     (rst1),
        .clk_out (clk_out1),
        .tick    (tick1)
    );

    always #1 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic t);
        vecs[nvec] = '{rst: r, exp_clk: c, exp_tick: t};
        nvec++;
    endtask

    // One clock edge, then sample on the following falling edge.
    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ticks;

        // Reset entry, then 12 edges after release (rises at 4 and 12, fall at 8).
        add(1, 0, 0); add(1, 0, 0); add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        add(0, 1, 0); add(0, 1, 0); add(0, 1, 0); add(0, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        // Reset two edges after a rise: drop at once, then a full 4-cycle low phase.
        add(0, 1, 0); add(0, 1, 0); add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 1, 0);
        // Finish the high phase, run the low phase to cnt=3, then reset on the toggle edge.
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0);
        add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);

        // Power-up state before any edge.
        #0.5;
        chk("pwrup_clk4",  clk_out4, 1'b0);
        chk("pwrup_tick4", tick4,    1'b0);
        chk("pwrup_clk1",  clk_out1, 1'b0);
        chk("pwrup_tick1", tick1,    1'b0);

        // Free run from power-up with rst low for 11 periods of the /8 instance.
        ticks = 0;
        for (int k = 1; k <= 88; k++) begin
            edge_step();
            chk($sformatf("run4_clk k=%0d", k),  clk_out4, logic'((k / 4) % 2));
            chk($sformatf("run4_tick k=%0d", k), tick4,    logic'((k % 8) == 4));
            chk($sformatf("run1_clk k=%0d", k),  clk_out1, logic'(k % 2));
            chk($sformatf("run1_tick k=%0d", k), tick1,    logic'(k % 2));
            if (tick4 === 1'b1) ticks++;
        end
        chk("run4_tick_count_is_11", logic'(ticks == 11), 1'b1);

        // Directed reset vectors for the /8 instance.
        for (int i = 0; i < nvec; i++) begin
            rst4 = vecs[i].rst;
            edge_step();
            chk($sformatf("vec%0d_clk", i),  clk_out4, vecs[i].exp_clk);
            chk($sformatf("vec%0d_tick", i), tick4,    vecs[i].exp_tick);
        end
        rst4 = 1'b0;

        // HALF_PERIOD=1: reset for two edges, then alternate every edge with tick on each rise.
        rst1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_step();
            chk($sformatf("hp1_rst_clk %0d", k),  clk_out1, 1'b0);
            chk($sformatf("hp1_rst_tick %0d", k), tick1,    1'b0);
        end
        rst1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            edge_step();
            chk($sformatf("hp1_clk k=%0d", k),  clk_out1, logic'(k % 2));
            chk($sformatf("hp1_tick k=%0d", k), tick1,    logic'(k % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
